// File: rtl/hamming16_pkg.sv
// ---------------------------------------------------------------------------
// hamming16_pkg
// Shared definitions for the 16-bit data / 10-parity Hamming link.
//   - Codeword layout: [15:0] = d0..d15, [25:16] = P0..P9
//   - COL_SIG[i]: set of parities covering data bit i (bit k set => P_k)
//   - calc_parity / hamming16_encode: used by the encoder stage, the
//     decoder and the bench so all three agree on one definition.
//   - mask_to_pos: flip mask -> corrected bit index (31 when no flip).
// ---------------------------------------------------------------------------
package hamming16_pkg;

  localparam int CODE_W   = 26;
  localparam int DATA_W   = 16;
  localparam int PAR_W    = 10;
  localparam int DATA_LSB = 0;
  localparam int PAR_LSB  = 16;
  localparam int POS_W    = 5;

  localparam logic [POS_W-1:0] POS_NONE = 5'd31;

  // Each data bit has a distinct, non-zero signature of weight >= 2, so it
  // can never alias a single parity-bit error (weight 1).
  localparam logic [PAR_W-1:0] COL_SIG [DATA_W] = '{
    10'h005, 10'h003, 10'h00C, 10'h006, 10'h007, 10'h009, 10'h00A, 10'h00B,
    10'h038, 10'h050, 10'h060, 10'h070, 10'h180, 10'h280, 10'h300, 10'h380
  };

  typedef enum logic [1:0] {
    DEC_CLEAN,
    DEC_CORR,
    DEC_UNCORR
  } dec_class_e;

  function automatic logic [PAR_W-1:0] calc_parity(input logic [DATA_W-1:0] data);
    logic [PAR_W-1:0] p;
    p = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (data[i]) p = p ^ COL_SIG[i];
    end
    return p;
  endfunction

  function automatic logic [CODE_W-1:0] hamming16_encode(input logic [DATA_W-1:0] data);
    return {calc_parity(data), data};
  endfunction

  function automatic logic [POS_W-1:0] mask_to_pos(input logic [CODE_W-1:0] mask);
    logic [POS_W-1:0] pos;
    pos = POS_NONE;
    for (int i = 0; i < CODE_W; i++) begin
      if (mask[i]) pos = POS_W'(i);
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming16_syndrome_corr.sv
// ---------------------------------------------------------------------------
// hamming16_syndrome_corr
// Combinational syndrome decode.
//   syndrome  in  10  recomputed parity XOR received parity
//   flip_mask out 26  one-hot bit to invert in the codeword (0 if none)
//   corr      out 1   single-bit error located (data or parity)
//   uncorr    out 1   non-zero syndrome matching no column
// ---------------------------------------------------------------------------
module hamming16_syndrome_corr
  import hamming16_pkg::*;
(
  input  logic [PAR_W-1:0]  syndrome,
  output logic [CODE_W-1:0] flip_mask,
  output logic              corr,
  output logic              uncorr
);

  dec_class_e dec_class;

  // Match the syndrome against every column; a non-zero syndrome that
  // matches nothing is a multi-bit error we cannot locate.
  always_comb begin
    flip_mask = '0;
    dec_class = DEC_CLEAN;
    if (syndrome != '0) begin
      dec_class = DEC_UNCORR;
      for (int i = 0; i < DATA_W; i++) begin
        if (syndrome == COL_SIG[i]) begin
          flip_mask[DATA_LSB + i] = 1'b1;
          dec_class = DEC_CORR;
        end
      end
      for (int k = 0; k < PAR_W; k++) begin
        if (syndrome == (PAR_W'(1) << k)) begin
          flip_mask[PAR_LSB + k] = 1'b1;
          dec_class = DEC_CORR;
        end
      end
    end
  end

  assign corr   = (dec_class == DEC_CORR);
  assign uncorr = (dec_class == DEC_UNCORR);

endmodule

// File: rtl/hamming16_decoder.sv
// ---------------------------------------------------------------------------
// hamming16_decoder
// Two-stage Hamming(26,16) receive decoder with valid/ready on both sides
// and saturating error counters.
//   i_SCLK, i_RESETB      clock (rising), async active-low reset
//   i_VALID/o_READY       upstream handshake, i_CODE[25:0] codeword
//   o_VALID/i_READY       downstream handshake
//   o_DATA[15:0]          corrected data
//   o_CORR / o_UNCORR     per-beat error flags
//   i_CNT_CLR             synchronous clear of counters (and error log)
//   o_CORR_CNT/o_UNCORR_CNT  saturating beat counts, CNT_W bits
// Optional (macro HAMMING_DEC_ERR_LOG_EN):
//   o_ERR_SYN[9:0], o_ERR_POS[4:0]  syndrome / bit index of last error beat
// ---------------------------------------------------------------------------
module hamming16_decoder
  import hamming16_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              i_SCLK,
  input  logic              i_RESETB,
  input  logic              i_VALID,
  output logic              o_READY,
  input  logic [CODE_W-1:0] i_CODE,
  output logic              o_VALID,
  input  logic              i_READY,
  output logic [DATA_W-1:0] o_DATA,
  output logic              o_CORR,
  output logic              o_UNCORR,
  input  logic              i_CNT_CLR,
  output logic [CNT_W-1:0]  o_CORR_CNT,
  output logic [CNT_W-1:0]  o_UNCORR_CNT
`ifdef HAMMING_DEC_ERR_LOG_EN
  ,
  output logic [PAR_W-1:0]  o_ERR_SYN,
  output logic [POS_W-1:0]  o_ERR_POS
`endif
);

  logic              v1, v2, en1, en2, out_hs;
  logic [DATA_W-1:0] data1;
  logic [PAR_W-1:0]  syn1, in_syn;
  logic [CODE_W-1:0] flip_mask;
  logic [DATA_W-1:0] fixed_data;
  logic              dec_corr, dec_uncorr;

  // A stage may load when it is empty or its contents move on this cycle.
  assign en2     = ~v2 | i_READY;
  assign en1     = ~v1 | en2;
  assign o_READY = en1;
  assign o_VALID = v2;
  assign out_hs  = v2 & i_READY;

  assign in_syn = calc_parity(i_CODE[DATA_LSB +: DATA_W]) ^ i_CODE[PAR_LSB +: PAR_W];

  // Stage 1: the data field plus its syndrome carry all the codeword's
  // information, so the received parity bits need not be kept.
  always_ff @(posedge i_SCLK or negedge i_RESETB) begin
    if (!i_RESETB) begin
      v1    <= 1'b0;
      data1 <= '0;
      syn1  <= '0;
    end else if (en1) begin
      v1 <= i_VALID;
      if (i_VALID) begin
        data1 <= i_CODE[DATA_LSB +: DATA_W];
        syn1  <= in_syn;
      end
    end
  end

  hamming16_syndrome_corr u_syndrome_corr (
    .syndrome  (syn1),
    .flip_mask (flip_mask),
    .corr      (dec_corr),
    .uncorr    (dec_uncorr)
  );

  assign fixed_data = data1 ^ flip_mask[DATA_LSB +: DATA_W];

  // Stage 2: outputs only change when a new beat moves in, so they hold
  // steady while downstream stalls.
  always_ff @(posedge i_SCLK or negedge i_RESETB) begin
    if (!i_RESETB) begin
      v2       <= 1'b0;
      o_DATA   <= '0;
      o_CORR   <= 1'b0;
      o_UNCORR <= 1'b0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        o_DATA   <= fixed_data;
        o_CORR   <= dec_corr;
        o_UNCORR <= dec_uncorr;
      end
    end
  end

  // Saturating counters; clear has priority over a same-cycle increment.
  always_ff @(posedge i_SCLK or negedge i_RESETB) begin
    if (!i_RESETB) begin
      o_CORR_CNT   <= '0;
      o_UNCORR_CNT <= '0;
    end else if (i_CNT_CLR) begin
      o_CORR_CNT   <= '0;
      o_UNCORR_CNT <= '0;
    end else begin
      if (out_hs && o_CORR && (o_CORR_CNT != '1))
        o_CORR_CNT <= o_CORR_CNT + CNT_W'(1);
      if (out_hs && o_UNCORR && (o_UNCORR_CNT != '1))
        o_UNCORR_CNT <= o_UNCORR_CNT + CNT_W'(1);
    end
  end

`ifdef HAMMING_DEC_ERR_LOG_EN
  logic [PAR_W-1:0] syn2;
  logic [POS_W-1:0] pos2;

  // Syndrome and position travel alongside the stage-2 beat.
  always_ff @(posedge i_SCLK or negedge i_RESETB) begin
    if (!i_RESETB) begin
      syn2 <= '0;
      pos2 <= '0;
    end else if (en2 && v1) begin
      syn2 <= syn1;
      pos2 <= mask_to_pos(flip_mask);
    end
  end

  // Error log captures on delivered error beats; clear zeroes it.
  always_ff @(posedge i_SCLK or negedge i_RESETB) begin
    if (!i_RESETB) begin
      o_ERR_SYN <= '0;
      o_ERR_POS <= '0;
    end else if (i_CNT_CLR) begin
      o_ERR_SYN <= '0;
      o_ERR_POS <= '0;
    end else if (out_hs && (o_CORR || o_UNCORR)) begin
      o_ERR_SYN <= syn2;
      o_ERR_POS <= pos2;
    end
  end
`else
  logic unused_par_flips;
  assign unused_par_flips = ^flip_mask[PAR_LSB +: PAR_W];
`endif

endmodule

// File: tb/tb_hamming16_decoder.sv
// ---------------------------------------------------------------------------
// tb_hamming16_decoder
// Self-checking bench for hamming16_decoder (CNT_W=4 so saturation is
// reachable). A scoreboard model decodes by brute-force nearest-codeword
// search and tracks outstanding beats; one compare process checks every
// cycle, and directed sections pin hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_hamming16_decoder;
  import hamming16_pkg::*;

  localparam int TB_CNT_W = 4;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic              i_SCLK = 1'b0;
  logic              i_RESETB = 1'b0;
  logic              i_VALID = 1'b0;
  logic              o_READY;
  logic [CODE_W-1:0] i_CODE = '0;
  logic              o_VALID;
  logic              i_READY = 1'b1;
  logic [DATA_W-1:0] o_DATA;
  logic              o_CORR, o_UNCORR;
  logic              i_CNT_CLR = 1'b0;
  logic [TB_CNT_W-1:0] o_CORR_CNT, o_UNCORR_CNT;
`ifdef HAMMING_DEC_ERR_LOG_EN
  logic [PAR_W-1:0]  o_ERR_SYN;
  logic [POS_W-1:0]  o_ERR_POS;
`endif

  int total = 0;
  int bad   = 0;

  hamming16_decoder #(.CNT_W(TB_CNT_W)) dut (
    .i_SCLK       (i_SCLK),
    .i_RESETB     (i_RESETB),
    .i_VALID      (i_VALID),
    .o_READY      (o_READY),
    .i_CODE       (i_CODE),
    .o_VALID      (o_VALID),
    .i_READY      (i_READY),
    .o_DATA       (o_DATA),
    .o_CORR       (o_CORR),
    .o_UNCORR     (o_UNCORR),
    .i_CNT_CLR    (i_CNT_CLR),
    .o_CORR_CNT   (o_CORR_CNT),
    .o_UNCORR_CNT (o_UNCORR_CNT)
`ifdef HAMMING_DEC_ERR_LOG_EN
    ,
    .o_ERR_SYN    (o_ERR_SYN),
    .o_ERR_POS    (o_ERR_POS)
`endif
  );

  always #5 i_SCLK = ~i_SCLK;

  // ---------------- reference model ----------------
  typedef struct {
    logic [DATA_W-1:0] data;
    logic              corr;
    logic              uncorr;
    logic [PAR_W-1:0]  syn;
    logic [POS_W-1:0]  pos;
    int                age;
  } beat_t;

  beat_t pipe_q[$];
  int    exp_corr_cnt = 0;
  int    exp_uncorr_cnt = 0;
  logic [PAR_W-1:0] exp_err_syn = '0;
  logic [POS_W-1:0] exp_err_pos = '0;

  function automatic logic [PAR_W-1:0] model_syn(input logic [CODE_W-1:0] code);
    logic [CODE_W-1:0] re;
    re = hamming16_encode(code[DATA_W-1:0]);
    return re[CODE_W-1:DATA_W] ^ code[CODE_W-1:DATA_W];
  endfunction

  // Nearest valid codeword at distance <= 1, else report raw data.
  function automatic beat_t model_decode(input logic [CODE_W-1:0] code);
    beat_t b;
    logic [CODE_W-1:0] t;
    b.data = code[DATA_W-1:0];
    b.corr = 1'b0;
    b.uncorr = 1'b0;
    b.syn = model_syn(code);
    b.pos = 5'd0;
    b.age = 0;
    if (hamming16_encode(code[DATA_W-1:0]) != code) begin
      b.uncorr = 1'b1;
      b.pos = 5'd31;
      for (int j = 0; j < CODE_W; j++) begin
        t = code ^ (26'd1 << j);
        if (hamming16_encode(t[DATA_W-1:0]) == t) begin
          b.corr = 1'b1;
          b.uncorr = 1'b0;
          b.pos = 5'(j);
          b.data = t[DATA_W-1:0];
        end
      end
    end
    return b;
  endfunction

  // Model update: a beat becomes visible one edge after its accepting edge
  // and leaves on the handshake; at most two beats can be outstanding.
  initial begin : model_proc
    beat_t b;
    logic hs, acc;
    forever begin
      @(posedge i_SCLK or negedge i_RESETB);
      if (!i_RESETB) begin
        pipe_q.delete();
        exp_corr_cnt = 0;
        exp_uncorr_cnt = 0;
        exp_err_syn = '0;
        exp_err_pos = '0;
      end else begin
        hs  = (pipe_q.size() > 0) && (pipe_q[0].age >= 1) && i_READY;
        acc = i_VALID && !((pipe_q.size() >= 2) && !i_READY);
        if (i_CNT_CLR) begin
          exp_corr_cnt = 0;
          exp_uncorr_cnt = 0;
          exp_err_syn = '0;
          exp_err_pos = '0;
        end else if (hs) begin
          if (pipe_q[0].corr && exp_corr_cnt < CNT_MAX) exp_corr_cnt++;
          if (pipe_q[0].uncorr && exp_uncorr_cnt < CNT_MAX) exp_uncorr_cnt++;
          if (pipe_q[0].corr || pipe_q[0].uncorr) begin
            exp_err_syn = pipe_q[0].syn;
            exp_err_pos = pipe_q[0].pos;
          end
        end
        if (hs) void'(pipe_q.pop_front());
        for (int i = 0; i < pipe_q.size(); i++) begin
          b = pipe_q[i];
          b.age++;
          pipe_q[i] = b;
        end
        if (acc) pipe_q.push_back(model_decode(i_CODE));
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, actual, expected, $time);
    end
  endtask

  // Compare process: every cycle out of reset, DUT against the model.
  initial begin : compare_proc
    logic exp_valid, exp_ready;
    forever begin
      @(negedge i_SCLK);
      if (i_RESETB) begin
        exp_valid = (pipe_q.size() > 0) && (pipe_q[0].age >= 1);
        exp_ready = !((pipe_q.size() >= 2) && !i_READY);
        checkOutput("cmp_o_VALID", 32'(o_VALID), 32'(exp_valid));
        checkOutput("cmp_o_READY", 32'(o_READY), 32'(exp_ready));
        checkOutput("cmp_corr_cnt", 32'(o_CORR_CNT), 32'(exp_corr_cnt));
        checkOutput("cmp_uncorr_cnt", 32'(o_UNCORR_CNT), 32'(exp_uncorr_cnt));
        if (exp_valid) begin
          checkOutput("cmp_o_DATA", 32'(o_DATA), 32'(pipe_q[0].data));
          checkOutput("cmp_o_CORR", 32'(o_CORR), 32'(pipe_q[0].corr));
          checkOutput("cmp_o_UNCORR", 32'(o_UNCORR), 32'(pipe_q[0].uncorr));
        end
`ifdef HAMMING_DEC_ERR_LOG_EN
        checkOutput("cmp_err_syn", 32'(o_ERR_SYN), 32'(exp_err_syn));
        checkOutput("cmp_err_pos", 32'(o_ERR_POS), 32'(exp_err_pos));
`endif
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic applyStimulus(input logic [CODE_W-1:0] code);
    @(posedge i_SCLK); #1;
    i_VALID = 1'b1;
    i_CODE  = code;
    @(posedge i_SCLK); #1;
    i_VALID = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    @(negedge i_SCLK);
    while (!o_VALID && n < 8) begin
      @(negedge i_SCLK);
      n++;
    end
    checkOutput({name, "_valid"}, 32'(o_VALID), 32'd1);
  endtask

  task automatic expect_beat(input string name, input logic [15:0] data,
                             input logic corr, input logic uncorr);
    wait_valid(name);
    checkOutput({name, "_data"}, 32'(o_DATA), 32'(data));
    checkOutput({name, "_corr"}, 32'(o_CORR), 32'(corr));
    checkOutput({name, "_uncorr"}, 32'(o_UNCORR), 32'(uncorr));
  endtask

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main_seq
    logic [CODE_W-1:0] code_a, code_b, code_c, tmp;
    logic [DATA_W-1:0] rec[$];
    logic [DATA_W-1:0] got;
    logic [DATA_W-1:0] exp_order [3];
    logic [DATA_W-1:0] rdata;
    int r;

    // Model pins: hand-derived syndromes and decodes.
    checkOutput("pin_syn_bit4", 32'(model_syn(26'h0000010)), 32'h007);
    checkOutput("pin_syn_p9", 32'(model_syn(26'h2000000)), 32'h200);
    checkOutput("pin_syn_8_12", 32'(model_syn(26'h0001100)), 32'h1B8);
    checkOutput("pin_dec_8_12", 32'(model_decode(26'h0001100).uncorr), 32'd1);

    repeat (3) @(negedge i_SCLK);
    checkOutput("rst_valid", 32'(o_VALID), 32'd0);
    checkOutput("rst_data", 32'(o_DATA), 32'd0);
    checkOutput("rst_corr", 32'(o_CORR), 32'd0);
    checkOutput("rst_uncorr", 32'(o_UNCORR), 32'd0);
    checkOutput("rst_ccnt", 32'(o_CORR_CNT), 32'd0);
    checkOutput("rst_ucnt", 32'(o_UNCORR_CNT), 32'd0);
    @(posedge i_SCLK); #1;
    i_RESETB = 1'b1;

    applyStimulus(26'h0);
    expect_beat("zero", 16'h0000, 1'b0, 1'b0);
    @(negedge i_SCLK);
    checkOutput("zero_ccnt", 32'(o_CORR_CNT), 32'd0);

    applyStimulus(26'h0000010);
    expect_beat("bit4", 16'h0000, 1'b1, 1'b0);
    @(negedge i_SCLK);
    checkOutput("bit4_ccnt", 32'(o_CORR_CNT), 32'd1);
`ifdef HAMMING_DEC_ERR_LOG_EN
    checkOutput("bit4_syn", 32'(o_ERR_SYN), 32'h007);
    checkOutput("bit4_pos", 32'(o_ERR_POS), 32'd4);
`endif

    applyStimulus(26'h2000000);
    expect_beat("p9", 16'h0000, 1'b1, 1'b0);
    @(negedge i_SCLK);
    checkOutput("p9_ccnt", 32'(o_CORR_CNT), 32'd2);

    applyStimulus(26'h0001100);
    expect_beat("b8_12", 16'h1100, 1'b0, 1'b1);
    @(negedge i_SCLK);
    checkOutput("b8_12_ucnt", 32'(o_UNCORR_CNT), 32'd1);
`ifdef HAMMING_DEC_ERR_LOG_EN
    checkOutput("b8_12_pos", 32'(o_ERR_POS), 32'd31);
`endif

    applyStimulus(hamming16_encode(16'hA5C3) ^ 26'h8);
    expect_beat("a5c3_b3", 16'hA5C3, 1'b1, 1'b0);

    // Backpressure: three beats offered while downstream stalls.
    code_a = hamming16_encode(16'h1111);
    code_b = hamming16_encode(16'h2222) ^ 26'h1;
    code_c = hamming16_encode(16'h3333);
    exp_order = '{16'h1111, 16'h2222, 16'h3333};
    @(posedge i_SCLK); #1;
    i_READY = 1'b0;
    i_VALID = 1'b1;
    i_CODE  = code_a;
    @(posedge i_SCLK); #1;
    i_CODE  = code_b;
    @(posedge i_SCLK); #1;
    i_CODE  = code_c;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_SCLK);
      checkOutput("bp_ready_low", 32'(o_READY), 32'd0);
      checkOutput("bp_hold_valid", 32'(o_VALID), 32'd1);
      checkOutput("bp_hold_data", 32'(o_DATA), 32'h1111);
      @(posedge i_SCLK); #1;
    end
    i_READY = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge i_SCLK);
      if (o_VALID) rec.push_back(o_DATA);
      @(posedge i_SCLK); #1;
      i_VALID = 1'b0;
    end
    checkOutput("bp_count", 32'(rec.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      got = (k < rec.size()) ? rec[k] : 16'hxxxx;
      checkOutput("bp_order", 32'(got), 32'(exp_order[k]));
    end

    // Saturation of the correctable counter.
    i_CNT_CLR = 1'b1;
    @(posedge i_SCLK); #1;
    i_CNT_CLR = 1'b0;
    @(negedge i_SCLK);
    checkOutput("clr_ccnt", 32'(o_CORR_CNT), 32'd0);
    checkOutput("clr_ucnt", 32'(o_UNCORR_CNT), 32'd0);
    for (int k = 0; k < 17; k++) begin
      tmp = 26'd1 << k;
      i_VALID = 1'b1;
      i_CODE  = tmp;
      @(posedge i_SCLK); #1;
    end
    i_VALID = 1'b0;
    repeat (4) @(posedge i_SCLK);
    @(negedge i_SCLK);
    checkOutput("sat_ccnt", 32'(o_CORR_CNT), 32'hF);
    checkOutput("sat_ucnt", 32'(o_UNCORR_CNT), 32'd0);

    // Clear coinciding with a correctable handshake.
    applyStimulus(26'h0000002);
    wait_valid("clr_hs");
    i_CNT_CLR = 1'b1;
    @(posedge i_SCLK); #1;
    i_CNT_CLR = 1'b0;
    @(negedge i_SCLK);
    checkOutput("clr_hs_ccnt", 32'(o_CORR_CNT), 32'd0);
`ifdef HAMMING_DEC_ERR_LOG_EN
    checkOutput("clr_hs_syn", 32'(o_ERR_SYN), 32'd0);
`endif

    // Randomized traffic with 0, 1 or 2 bit errors and random stalls.
    for (int k = 0; k < 800; k++) begin
      @(posedge i_SCLK); #1;
      rdata = 16'($urandom);
      tmp = hamming16_encode(rdata);
      r = int'($urandom_range(0, 9));
      if (r >= 4) tmp = tmp ^ (26'd1 << $urandom_range(0, 25));
      if (r >= 8) tmp = tmp ^ (26'd1 << $urandom_range(0, 25));
      i_CODE    = tmp;
      i_VALID   = ($urandom_range(0, 3) != 0);
      i_READY   = ($urandom_range(0, 3) != 0);
      i_CNT_CLR = ($urandom_range(0, 59) == 0);
    end

    // Reset while the pipeline is full and stalled.
    @(posedge i_SCLK); #1;
    i_CNT_CLR = 1'b0;
    i_READY   = 1'b0;
    i_VALID   = 1'b1;
    i_CODE    = hamming16_encode(16'hBEEF) ^ 26'h100;
    repeat (3) @(posedge i_SCLK);
    #3;
    i_RESETB = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(o_VALID), 32'd0);
    checkOutput("mid_rst_data", 32'(o_DATA), 32'd0);
    checkOutput("mid_rst_corr", 32'(o_CORR), 32'd0);
    checkOutput("mid_rst_ccnt", 32'(o_CORR_CNT), 32'd0);
    checkOutput("mid_rst_ucnt", 32'(o_UNCORR_CNT), 32'd0);
    i_VALID = 1'b0;
    i_READY = 1'b1;
    @(posedge i_SCLK); #1;
    i_RESETB = 1'b1;
    repeat (3) @(negedge i_SCLK);
    checkOutput("post_rst_valid", 32'(o_VALID), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hamming16_decoder.md
Name: hamming16_decoder

Overview:
- Receive-side stage that consumes the 26-bit codeword produced by the 16-bit/10-parity Hamming encoder stage.
- Recomputes the 10 parities, forms the syndrome, corrects any single-bit error (data or parity), flags uncorrectable patterns, and outputs the 16-bit data word.
- Two-stage pipeline with valid/ready handshake on both sides; saturating error counters for link-health monitoring.

Parameters:
- CNT_W, 16, width of each saturating error counter

Ports:
- i_SCLK  input  1  clock, rising edge
- i_RESETB  input  1  reset, asynchronous, active-low
- i_VALID  input  1  upstream codeword valid
- o_READY  output  1  decoder can accept a codeword this cycle
- i_CODE  input  26  codeword: [15:0] = d0..d15, [25:16] = P0..P9
- o_VALID  output  1  decoded word valid
- i_READY  input  1  downstream accepts the decoded word
- o_DATA  output  16  corrected data
- o_CORR  output  1  single-bit error corrected on this beat (data or parity)
- o_UNCORR  output  1  non-zero syndrome matching no column
- i_CNT_CLR  input  1  synchronous clear of both counters
- o_CORR_CNT  output  CNT_W  saturating count of o_CORR beats
- o_UNCORR_CNT  output  CNT_W  saturating count of o_UNCORR beats

Behaviour:
- Reset (i_RESETB low, asynchronous): all pipeline valids 0, o_VALID=0, o_DATA=0, o_CORR=0, o_UNCORR=0, both counters 0. Reset mid-operation discards in-flight beats.
- Column signatures (parity index sets):
  - d0{0,2} d1{0,1} d2{2,3} d3{1,2} d4{0,1,2} d5{0,3} d6{1,3} d7{0,1,3}
  - d8{3,4,5} d9{4,6} d10{5,6} d11{4,5,6}
  - d12{7,8} d13{7,9} d14{8,9} d15{7,8,9}
  - Pk{k}
  - All signatures are distinct and non-zero. P_k is the XOR of every data bit whose signature contains k.
- Stage 1 (on accept): registers the codeword and the syndrome S[9:0] = recomputed parity XOR received parity.
- Stage 2: decode.
  - S==0: data passes through unchanged, no flags.
  - S matches a data column: that data bit is inverted; o_CORR=1.
  - S is one-hot: a parity bit is in error; data unchanged; o_CORR=1.
  - Otherwise: raw data is output; o_UNCORR=1.
  - o_CORR and o_UNCORR are never both 1.
- Latency: 2 cycles from accept (i_VALID & o_READY) to o_VALID, absent backpressure. Throughput is 1 word per cycle.
- Handshake:
  - en2 = ~v2 | i_READY; en1 = ~v1 | en2; o_READY = en1. This is combinational, with no dependency on i_VALID.
  - o_DATA, o_CORR and o_UNCORR are held stable while o_VALID & ~i_READY.
  - A beat is accepted only on i_VALID & o_READY; i_CODE is ignored otherwise.
- Counters:
  - Each increments by 1 on a handshake (o_VALID & i_READY) carrying its flag.
  - Each saturates at all-ones with no wrap.
  - i_CNT_CLR sets both to 0 and wins over a simultaneous increment.

Optional Feature:
- Macro: HAMMING_DEC_ERR_LOG_EN.
- Defined: adds outputs o_ERR_SYN[9:0] and o_ERR_POS[4:0].
  - On every handshake with o_CORR or o_UNCORR, these capture the syndrome and the corrected bit index (0-15 data, 16-25 parity; 31 if uncorrectable).
  - They hold until the next error or i_CNT_CLR, which zeroes them. Reset value is 0.
- Undefined: the ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package hamming16_pkg:
  - Codeword width (26), data width (16), parity count (10).
  - Field positions.
  - Column-signature constant array.
  - Function that encodes 16 bits to 26 bits, shared with the encoder stage and the bench.
- One sub-module, hamming16_syndrome_corr: combinational syndrome-to-correction-mask decode, producing a 26-bit flip mask plus corr/uncorr flags.

Test Plan:
- Codeword 26'h0 streamed with i_READY=1 -> o_DATA=16'h0000 two cycles later; no flags; counters stay 0.
- Zero codeword with bit 4 flipped (26'h0000010) -> S=10'h007, o_DATA=16'h0000, o_CORR=1, o_CORR_CNT=1.
- Zero codeword with bit 25 flipped (P9) -> S=10'h200, o_DATA=16'h0000, o_CORR=1.
- Zero codeword with bits 8 and 12 flipped -> S=10'h1B8, o_UNCORR=1, o_DATA=16'h1100, o_UNCORR_CNT=1.
- i_READY=0 while 3 valid beats are offered -> 2 accepted, then o_READY=0; o_DATA stays stable; raising i_READY drains all 3 in order with no loss or duplication.
- CNT_W=4, 17 correctable beats -> o_CORR_CNT=4'hF. i_CNT_CLR asserted with a correctable handshake in the same cycle -> counter 0.
